// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues instruction reads to main memory, waits for Done,
// and hands the captured word to decode over valid/ready, with branch redirect and timeout.
module instruction_fetch_unit #(
    parameter int WIDTH     = 13,
    parameter int MEM_DEPTH = 13,
    parameter int TIMEOUT   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_instruction,
    input  logic [WIDTH-1:0] mem_data_in,
    input  logic             mem_done,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             fetch_error
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(MEM_DEPTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  pc_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  mem_address_q;
    logic              mem_read_q;
    logic [WIDTH-1:0]  instr_out_q;
    logic [WIDTH-1:0]  instr_pc_q;
    logic              instr_valid_q;
    logic              fetch_error_q;

    logic [WIDTH-1:0]  pc_inc_d;
    logic [WIDTH-1:0]  pc_seq_d;
    logic              tgt_ok_d;
    logic [WIDTH-1:0]  branch_pc_d;

    // pc+1 is evaluated at WIDTH bits and then folded back into the memory range
    assign pc_inc_d    = pc_q + WIDTH'(1);
    assign pc_seq_d    = (pc_inc_d >= DEPTH_W) ? '0 : pc_inc_d;
    assign tgt_ok_d    = (branch_target < DEPTH_W);
    assign branch_pc_d = tgt_ok_d ? branch_target : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            cnt_q         <= '0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            fetch_error_q <= 1'b0;
            if (branch_taken) begin
                // Redirect wins over done, handshake and timeout; an idle, disabled unit only moves its PC
                pc_q          <= branch_pc_d;
                fetch_error_q <= !tgt_ok_d;
                if (state_q != S_IDLE || enable) begin
                    state_q       <= S_REQ;
                    instr_valid_q <= 1'b0;
                    cnt_q         <= '0;
                    mem_read_q    <= 1'b1;
                    mem_address_q <= branch_pc_d;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (enable) begin
                            state_q       <= S_REQ;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= pc_q;
                        end
                    end
                    S_REQ: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (mem_done) begin
                            instr_out_q   <= mem_data_in;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            pc_q          <= pc_seq_d;
                            cnt_q         <= '0;
                            mem_read_q    <= 1'b0;
                            state_q       <= S_HOLD;
                        end else if (cnt_q == CNT_LAST) begin
                            fetch_error_q <= 1'b1;
                            cnt_q         <= '0;
                            state_q       <= S_REQ;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_HOLD: begin
                        if (instr_ready) begin
                            instr_valid_q <= 1'b0;
                            if (enable) begin
                                state_q       <= S_REQ;
                                mem_read_q    <= 1'b1;
                                mem_address_q <= pc_q;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_address     = mem_address_q;
    assign mem_read        = mem_read_q;
    assign mem_instruction = mem_read_q;
    assign mem_write       = 1'b0;
    assign instr_out       = instr_out_q;
    assign instr_pc        = instr_pc_q;
    assign instr_valid     = instr_valid_q;
    assign fetch_error     = fetch_error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural fetch model.
module tb_instruction_fetch_unit;

    localparam int WIDTH     = 13;
    localparam int MEM_DEPTH = 13;
    localparam int TIMEOUT   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] mem_address;
    logic             mem_read;
    logic             mem_write;
    logic             mem_instruction;
    logic [WIDTH-1:0] mem_data_in;
    logic             mem_done;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic             fetch_error;

    instruction_fetch_unit #(.WIDTH(WIDTH), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_instruction(mem_instruction), .mem_data_in(mem_data_in), .mem_done(mem_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory behaviour driven by the bench ----------------
    logic [WIDTH-1:0] rom [MEM_DEPTH];
    int mem_mode;   // 0: never done, 1: done whenever a read is out, 2: random latency, random data
    int done_pct;

    task automatic step();
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        case (mem_mode)
            0: mem_done = 1'b0;
            1: mem_done = mem_read;
            default: mem_done = mem_read && ($urandom_range(0, 99) < done_pct);
        endcase
        if (mem_mode == 2) mem_data_in = WIDTH'($urandom);
        else if (mem_address < MEM_DEPTH) mem_data_in = rom[mem_address];
        else mem_data_in = '0;
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 request cycle, 2 waiting on memory, 3 instruction held for decode
    int               m_phase;
    int               m_pc;
    int               m_waits;
    logic             m_init = 1'b0;
    logic [WIDTH-1:0] m_addr, m_out, m_ipc;
    logic             m_read, m_valid, m_err;

    always @(posedge clk) begin
        automatic int ph = m_phase, pc = m_pc, w = m_waits;
        automatic logic [WIDTH-1:0] a = m_addr, o = m_out, ip = m_ipc;
        automatic logic v = m_valid, e = 1'b0;
        if (reset) begin
            ph = 0; pc = 0; w = 0; a = '0; o = '0; ip = '0; v = 1'b0;
        end else if (branch_taken) begin
            if (int'(branch_target) < MEM_DEPTH) pc = int'(branch_target);
            else begin pc = 0; e = 1'b1; end
            if (ph != 0 || enable) begin ph = 1; v = 1'b0; w = 0; end
        end else begin
            case (ph)
                0: if (enable) ph = 1;
                1: ph = 2;
                2: begin
                    if (mem_done) begin
                        o = mem_data_in; ip = WIDTH'(pc); v = 1'b1;
                        pc = (pc + 1) % MEM_DEPTH; w = 0; ph = 3;
                    end else if (w + 1 == TIMEOUT) begin
                        e = 1'b1; w = 0; ph = 1;
                    end else w = w + 1;
                end
                default: if (instr_ready) begin v = 1'b0; ph = enable ? 1 : 0; end
            endcase
        end
        if (ph == 1 || ph == 2) a = WIDTH'(pc);
        m_phase <= ph; m_pc <= pc; m_waits <= w;
        m_addr <= a; m_out <= o; m_ipc <= ip; m_valid <= v; m_err <= e;
        m_read <= (ph == 1 || ph == 2);
        if (reset) m_init <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("mem_read", mem_read, m_read);
            check("mem_instruction", mem_instruction, m_read);
            check("mem_write", mem_write, 1'b0);
            check("mem_address", mem_address, m_addr);
            check("instr_valid", instr_valid, m_valid);
            check("instr_out", instr_out, m_out);
            check("instr_pc", instr_pc, m_ipc);
            check("fetch_error", fetch_error, m_err);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic found, seen_err;
        reset = 1'b1; enable = 1'b0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        mem_done = 1'b0; mem_data_in = '0;
        mem_mode = 1; done_pct = 50;
        for (int i = 0; i < MEM_DEPTH; i++) rom[i] = WIDTH'($urandom);
        rom[0] = 13'h0012;

        // Reset for two cycles, then enable with an immediately answering memory
        step(); step();
        reset = 1'b0; enable = 1'b1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_err", fetch_error, 0);
        step();
        check("c1_mem_read", mem_read, 1);
        check("c1_addr", mem_address, 0);
        step();
        check("c2_mem_read", mem_read, 1);
        check("c2_valid", instr_valid, 0);
        step();
        check("c3_valid", instr_valid, 1);
        check("c3_instr_out", instr_out, 13'h0012);
        check("c3_instr_pc", instr_pc, 0);

        // Decode stalls for five cycles
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", instr_valid, 1);
            check("stall_out", instr_out, 13'h0012);
            check("stall_no_read", mem_read, 0);
            step();
        end
        instr_ready = 1'b1;
        step();
        check("next_read", mem_read, 1);
        check("next_addr", mem_address, 1);
        check("next_valid", instr_valid, 0);

        // Continuous fetch through the top address and back to 0
        found = 1'b0; seen_err = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (fetch_error) seen_err = 1'b1;
            if (mem_read && mem_address == 0) found = 1'b1;
        end
        check("wrap_reached", found, 1);
        check("wrap_no_error", seen_err, 0);
        check("wrap_last_pc", instr_pc, 12);
        check("wrap_last_out", instr_out, rom[12]);

        // Branch while memory answers: data dropped, refetch at target
        step();
        branch_taken = 1'b1; branch_target = 13'd5;
        step();
        check("br_valid", instr_valid, 0);
        check("br_read", mem_read, 1);
        check("br_addr", mem_address, 5);
        check("br_err", fetch_error, 0);
        branch_taken = 1'b1; branch_target = 13'd20;
        step();
        check("br_oor_err", fetch_error, 1);
        check("br_oor_addr", mem_address, 0);
        check("br_oor_read", mem_read, 1);

        // Memory never answers: timeout after TIMEOUT waiting cycles, retry same address
        mem_mode = 0; mem_done = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            check("to_quiet", fetch_error, 0);
        end
        step();
        check("to_err", fetch_error, 1);
        check("to_addr", mem_address, 0);
        check("to_read", mem_read, 1);
        step();
        check("to_err_pulse", fetch_error, 0);

        // Reset while waiting, then while holding an instruction
        reset = 1'b1;
        step();
        check("rw_read", mem_read, 0);
        check("rw_valid", instr_valid, 0);
        check("rw_out", instr_out, 0);
        check("rw_pc", instr_pc, 0);
        reset = 1'b0; mem_mode = 1; instr_ready = 1'b0;
        step();
        check("rw_restart_addr", mem_address, 0);
        step(); step();
        check("rh_valid_before", instr_valid, 1);
        reset = 1'b1;
        step();
        check("rh_valid", instr_valid, 0);
        check("rh_out", instr_out, 0);
        check("rh_addr", mem_address, 0);
        check("rh_read", mem_read, 0);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int blk = 0; blk < 8; blk++) begin
            mem_mode = (blk == 0) ? 1 : 2;
            case (blk % 4)
                0: done_pct = 100;
                1: done_pct = 40;
                2: done_pct = 10;
                default: done_pct = 0;
            endcase
            for (int i = 0; i < 400; i++) begin
                enable        = ($urandom_range(0, 99) < 80);
                instr_ready   = ($urandom_range(0, 99) < 55);
                branch_taken  = ($urandom_range(0, 99) < 5);
                branch_target = WIDTH'($urandom_range(0, 20));
                reset         = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        reset = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
